modulo_requester: RTL and testbench

MODULO_REQUESTER -- requirements
Module: modulo_requester

---
 rtl/modulo_requester_pkg.sv | 19 +
 rtl/modulo_requester_if.sv | 33 +++
 rtl/modreq_watchdog.sv | 25 ++
 rtl/modulo_defs.vh | 14 +
 rtl/modulo_requester.sv | 115 +++++++++++
 tb/tb_modulo_requester.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/modulo_requester_pkg.sv
// rtl/modulo_requester_pkg.sv - state and error-code types for modulo_requester, built from modulo_defs.vh
`include "modulo_defs.vh"

package modulo_requester_pkg;

    typedef enum logic [1:0] {
        IDLE  = `ST_IDLE,
        ISSUE = `ST_ISSUE,
        WAIT  = `ST_WAIT,
        RESP  = `ST_RESP
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_OK      = `ERR_OK;
    localparam err_t ERR_DIV0    = `ERR_DIV0;
    localparam err_t ERR_TIMEOUT = `ERR_TIMEOUT;

endpackage

// File: rtl/modulo_requester_if.sv
// rtl/modulo_requester_if.sv - request, response and modulo-unit signal bundle for modulo_requester
interface modulo_requester_if
    import modulo_requester_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] req_zahl1_i;
    logic [WIDTH-1:0] req_zahl2_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_erg_o;
    err_t             rsp_err_o;
    logic [WIDTH-1:0] mod_zahl1_o;
    logic [WIDTH-1:0] mod_zahl2_o;
    logic             mod_start_o;
    logic             mod_valid_i;
    logic [WIDTH-1:0] mod_erg_i;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_zahl1_i, req_zahl2_i, rsp_ready_i, mod_valid_i, mod_erg_i,
        output req_ready_o, rsp_valid_o, rsp_erg_o, rsp_err_o,
               mod_zahl1_o, mod_zahl2_o, mod_start_o, busy_o
    );

    modport master (
        output req_valid_i, req_zahl1_i, req_zahl2_i, rsp_ready_i, mod_valid_i, mod_erg_i,
        input  req_ready_o, rsp_valid_o, rsp_erg_o, rsp_err_o,
               mod_zahl1_o, mod_zahl2_o, mod_start_o, busy_o
    );
endinterface

// File: rtl/modreq_watchdog.sv
// rtl/modreq_watchdog.sv - WAIT-state cycle counter that flags expiry on the LIMIT-th enabled cycle
module modreq_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // count holds the number of completed WAIT cycles, so LIMIT-1 marks the last allowed one
    assign expired = enable && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/modulo_defs.vh
// rtl/modulo_defs.vh - shared FSM state encodings and error codes for modulo_requester
`ifndef MODULO_DEFS_VH
`define MODULO_DEFS_VH

`define ST_IDLE     2'd0
`define ST_ISSUE    2'd1
`define ST_WAIT     2'd2
`define ST_RESP     2'd3

`define ERR_OK      2'd0
`define ERR_DIV0    2'd1
`define ERR_TIMEOUT 2'd2

`endif

// File: rtl/modulo_requester.sv
// rtl/modulo_requester.sv - single-outstanding modulo request sequencer; MODREQ_TIMEOUT_EN adds a WAIT watchdog
module modulo_requester
    import modulo_requester_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_i,
    modulo_requester_if.slave bus
);
    state_t           state;
    logic             ready_q;
    logic             busy_q;
    logic             rsp_valid_q;
    logic             mod_start_q;
    logic [WIDTH-1:0] rsp_erg_q;
    err_t             rsp_err_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;

`ifdef MODREQ_TIMEOUT_EN
    logic expired;

    modreq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst_i),
        .clear   (state == ISSUE),
        .enable  (state == WAIT),
        .expired (expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            mod_start_q <= 1'b0;
            rsp_erg_q   <= '0;
            rsp_err_q   <= ERR_OK;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            mod_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        op1_q   <= bus.req_zahl1_i;
                        op2_q   <= bus.req_zahl2_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        // trivial cases are answered locally without the modulo unit
                        if (bus.req_zahl2_i == '0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_erg_q   <= '0;
                            rsp_err_q   <= ERR_DIV0;
                        end else if (bus.req_zahl1_i < bus.req_zahl2_i) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_erg_q   <= bus.req_zahl1_i;
                            rsp_err_q   <= ERR_OK;
                        end else begin
                            state       <= ISSUE;
                            mod_start_q <= 1'b1;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.mod_valid_i) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_erg_q   <= bus.mod_erg_i;
                        rsp_err_q   <= ERR_OK;
                    end
`ifdef MODREQ_TIMEOUT_EN
                    else if (expired) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_erg_q   <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ready is withheld for the whole reset cycle, not just after the first reset edge
    assign bus.req_ready_o = ready_q & ~rst_i;
    assign bus.busy_o      = busy_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_erg_o   = rsp_erg_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.mod_start_o = mod_start_q;
    assign bus.mod_zahl1_o = op1_q;
    assign bus.mod_zahl2_o = op2_q;
endmodule

// File: tb/tb_modulo_requester.sv
// tb/tb_modulo_requester.sv - directed and randomized self-checking bench for modulo_requester
module tb_modulo_requester;
    localparam int W  = 16;
    localparam int TO = 16;
    localparam logic [1:0] E_OK  = 2'd0;
    localparam logic [1:0] E_DIV0 = 2'd1;
    localparam logic [1:0] E_TO  = 2'd2;

    logic clk = 1'b0;
    logic rst_i;
    int   n_pass   = 0;
    int   n_total  = 0;
    int   n_starts = 0;

    modulo_requester_if #(.WIDTH(W)) bus ();

    modulo_requester #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mod_start_o === 1'b1) n_starts++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: remainder by plain arithmetic, zero divisor flagged, small dividends answered directly
    task automatic run_req(input logic [W-1:0] z1, input logic [W-1:0] z2, input int lat, input int hold);
        logic [W-1:0] exp_erg;
        logic [1:0]   exp_err;
        logic         fast;
        int           starts0;
        if (z2 == '0) begin
            exp_erg = '0;
            exp_err = E_DIV0;
            fast    = 1'b1;
        end else begin
            exp_erg = z1 % z2;
            exp_err = E_OK;
            fast    = (z1 < z2);
        end
        starts0 = n_starts;
        check("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        check("busy_idle", 32'(bus.busy_o), 32'd0);
        bus.req_valid_i = 1'b1;
        bus.req_zahl1_i = z1;
        bus.req_zahl2_i = z2;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_zahl1_i = 16'($urandom);
        bus.req_zahl2_i = 16'($urandom);
        check("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
        check("busy_active", 32'(bus.busy_o), 32'd1);
        if (fast) begin
            check("fast_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        end else begin
            check("start_after_accept", 32'(bus.mod_start_o), 32'd1);
            check("rsp_valid_issue", 32'(bus.rsp_valid_o), 32'd0);
            @(negedge clk);
            check("start_one_cycle", 32'(bus.mod_start_o), 32'd0);
            check("mod_zahl1", 32'(bus.mod_zahl1_o), 32'(z1));
            check("mod_zahl2", 32'(bus.mod_zahl2_o), 32'(z2));
            if (lat > 0) begin
                repeat (lat - 1) begin
                    check("rsp_valid_wait", 32'(bus.rsp_valid_o), 32'd0);
                    @(negedge clk);
                end
                bus.mod_valid_i = 1'b1;
                bus.mod_erg_i   = bus.mod_zahl1_o % bus.mod_zahl2_o;
            end else begin
                repeat (TO - 1) begin
                    check("rsp_valid_pre_to", 32'(bus.rsp_valid_o), 32'd0);
                    @(negedge clk);
                end
                exp_erg = '0;
                exp_err = E_TO;
            end
            check("mod_zahl1_stable", 32'(bus.mod_zahl1_o), 32'(z1));
            check("mod_zahl2_stable", 32'(bus.mod_zahl2_o), 32'(z2));
            @(negedge clk);
            bus.mod_valid_i = 1'b0;
            check("rsp_valid_done", 32'(bus.rsp_valid_o), 32'd1);
        end
        check("rsp_erg", 32'(bus.rsp_erg_o), 32'(exp_erg));
        check("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
        repeat (hold) begin
            bus.mod_valid_i = 1'b1;
            bus.mod_erg_i   = 16'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("hold_erg", 32'(bus.rsp_erg_o), 32'(exp_erg));
            check("hold_err", 32'(bus.rsp_err_o), 32'(exp_err));
            check("hold_req_ready", 32'(bus.req_ready_o), 32'd0);
        end
        bus.mod_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("rsp_valid_after_hs", 32'(bus.rsp_valid_o), 32'd0);
        check("start_count", 32'(n_starts - starts0), fast ? 32'd0 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int b;
        int mode;
        rst_i           = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_zahl1_i = '0;
        bus.req_zahl2_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.mod_valid_i = 1'b0;
        bus.mod_erg_i   = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_erg", 32'(bus.rsp_erg_o), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        check("rst_mod_start", 32'(bus.mod_start_o), 32'd0);
        check("rst_mod_zahl1", 32'(bus.mod_zahl1_o), 32'd0);
        check("rst_mod_zahl2", 32'(bus.mod_zahl2_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready_o), 32'd1);

        run_req(16'd17, 16'd5, 8, 0);
        run_req(16'd9, 16'd0, 1, 0);
        run_req(16'd3, 16'd7, 1, 5);
        run_req(16'd7, 16'd7, 2, 1);
        run_req(16'd0, 16'd0, 1, 0);
        run_req(16'd0, 16'd5, 1, 0);
        run_req(16'd65535, 16'd1, 3, 0);
        run_req(16'd65535, 16'd65534, 1, 2);

`ifdef MODREQ_TIMEOUT_EN
        run_req(16'd50, 16'd3, -1, 1);
        run_req(16'd50, 16'd3, TO, 0);
`endif

        // reset while waiting on the modulo unit, then a stale completion arrives
        bus.req_valid_i = 1'b1;
        bus.req_zahl1_i = 16'd50;
        bus.req_zahl2_i = 16'd7;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("wait_rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("wait_rst_busy", 32'(bus.busy_o), 32'd0);
        check("wait_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("wait_rst_mod_zahl1", 32'(bus.mod_zahl1_o), 32'd0);
        rst_i           = 1'b0;
        bus.mod_valid_i = 1'b1;
        bus.mod_erg_i   = 16'd1;
        @(negedge clk);
        bus.mod_valid_i = 1'b0;
        check("late_valid_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check("late_valid_ready", 32'(bus.req_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        check("late_valid_idle", 32'(bus.rsp_valid_o), 32'd0);
        check("late_valid_busy", 32'(bus.busy_o), 32'd0);
        run_req(16'd100, 16'd7, 3, 0);

        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(3, 0);
            if (mode == 0) begin
                a = $urandom_range(65535, 0);
                b = 0;
            end else if (mode == 1) begin
                b = $urandom_range(65535, 1);
                a = $urandom_range(b - 1, 0);
            end else begin
                b = $urandom_range(300, 1);
                a = $urandom_range(65535, b);
            end
            run_req(16'(a), 16'(b), $urandom_range(12, 1), (i % 4 == 3) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
